// File: rtl/async_local_rx.sv
// Local-port sink of the switch's 4-phase bundled-data link: synchronises req,
// buffers flits in a small FIFO, checks framing/destination and streams flits out.
module async_local_rx #(
    parameter int WIDTH     = 64,
    parameter int LocationX = 2,
    parameter int LocationY = 2,
    parameter int COORD_W   = 4,
    parameter int DEPTH     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gen_enable,
    input  logic             req_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ack_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_sop_o,
    output logic             out_eop_o,
    output logic [15:0]      pkt_count_o,
    output logic             err_frame_o,
    output logic             err_dest_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t             state_q, state_d;
    logic               req_s1_q, req_s1_d, req_s2_q, req_s2_d;
    logic               ack_q, ack_d;
    logic [WIDTH+1:0]   mem_q [DEPTH];
    logic [WIDTH+1:0]   mem_d [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_sop_q, out_sop_d, out_eop_q, out_eop_d;
    logic [15:0]        pkt_count_q, pkt_count_d;
    logic               err_frame_q, err_frame_d, err_dest_q, err_dest_d;

    logic               is_head, is_tail, full, push, pop, avail, dest_bad;
    logic [COORD_W-1:0] dst_x, dst_y;
    logic [WIDTH+1:0]   head_entry;

    // Type bit 0 marks a packet start, bit 1 a packet end (single = both).
    assign is_head  = data_i[WIDTH-2];
    assign is_tail  = data_i[WIDTH-1];
    assign dst_x    = data_i[WIDTH-3 -: COORD_W];
    assign dst_y    = data_i[WIDTH-3-COORD_W -: COORD_W];
    assign dest_bad = (dst_x != COORD_W'(LocationX)) || (dst_y != COORD_W'(LocationY));

    assign full = (count_q == CW'(DEPTH));
    assign push = req_s2_q & ~ack_q & ~full & gen_enable;
    assign pop  = out_valid_q & out_ready_i;

    // The output register only shows entries already in memory before this
    // edge, so a freshly written flit appears one cycle after its write.
    assign avail      = pop ? (count_q > CW'(1)) : (count_q != '0);
    assign head_entry = mem_q[rd_ptr_d];

    always_comb begin
        state_d     = state_q;
        req_s1_d    = req_i;
        req_s2_d    = req_s1_q;
        ack_d       = ack_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q + PW'(push);
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        count_d     = count_q + CW'(push) - CW'(pop);
        pkt_count_d = pkt_count_q;
        err_frame_d = err_frame_q;
        err_dest_d  = err_dest_q;

        if (push)
            ack_d = 1'b1;
        else if (!req_s2_q && ack_q)
            ack_d = 1'b0;

        if (push) begin
            mem_d[wr_ptr_q] = {is_tail, is_head, data_i};
            if (is_tail)
                pkt_count_d = pkt_count_q + 16'd1;
            if (is_head && dest_bad)
                err_dest_d = 1'b1;
            case (state_q)
                IDLE: begin
                    if (is_head)
                        state_d = is_tail ? IDLE : IN_PKT;
                    else
                        err_frame_d = 1'b1;
                end
                IN_PKT: begin
                    if (is_head) begin
                        err_frame_d = 1'b1;
                        state_d     = is_tail ? IDLE : IN_PKT;
                    end else if (is_tail) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        out_valid_d = avail;
        out_data_d  = avail ? head_entry[WIDTH-1:0] : '0;
        out_sop_d   = avail & head_entry[WIDTH];
        out_eop_d   = avail & head_entry[WIDTH+1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_s1_q    <= 1'b0;
            req_s2_q    <= 1'b0;
            ack_q       <= 1'b0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            pkt_count_q <= '0;
            err_frame_q <= 1'b0;
            err_dest_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_s1_q    <= req_s1_d;
            req_s2_q    <= req_s2_d;
            ack_q       <= ack_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            pkt_count_q <= pkt_count_d;
            err_frame_q <= err_frame_d;
            err_dest_q  <= err_dest_d;
        end
    end

    assign ack_o       = ack_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sop_o   = out_sop_q;
    assign out_eop_o   = out_eop_q;
    assign pkt_count_o = pkt_count_q;
    assign err_frame_o = err_frame_q;
    assign err_dest_o  = err_dest_q;
endmodule
